// File: rtl/tech_sync_pkg.sv
// Shared definitions for the tech_sync_* family: counter sizing, parameter
// limits and the per-cycle filter decision type.
package tech_sync_pkg;

    localparam int MIN_DEPTH         = 2;
    localparam int MIN_FILTER_CYCLES = 1;

    // What the stability filter does with a channel on an enabled cycle.
    typedef enum logic [1:0] {
        FILT_IDLE   = 2'd0,  // synced level agrees with q, count cleared
        FILT_COUNT  = 2'd1,  // level differs, still inside the window
        FILT_UPDATE = 2'd2   // level differed for the whole window, q follows
    } filt_action_e;

    // Counter width: clog2 of the window, never narrower than one bit.
    function automatic int cnt_width(input int fc);
        int w;
        w = $clog2(fc);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tech_sync_filter_chan.sv
// One channel of tech_sync_filter: DEPTH-stage synchroniser, stability
// counter, filtered level and (when TECH_SYNC_FILTER_EDGES_EN is defined)
// the registered rise/fall pulses.
module tech_sync_filter_chan
    import tech_sync_pkg::*;
#(
    parameter int DEPTH         = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic clk__enable,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
`ifdef TECH_SYNC_FILTER_EDGES_EN
    ,
    output logic edge_o
`endif
);

    localparam int            CW      = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

    logic [DEPTH-1:0] sync_d, sync_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic             q_d, q_q;
    logic             s;
    filt_action_e     act;

    assign s = sync_q[DEPTH-1];
    assign q = q_q;

    // Next state of the synchroniser chain, the stability counter and q.
    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], d};
        cnt_d  = cnt_q;
        q_d    = q_q;
        if (s == q_q) begin
            act = FILT_IDLE;
        end else if (cnt_q == CNT_MAX) begin
            act = FILT_UPDATE;
        end else begin
            act = FILT_COUNT;
        end
        case (act)
            FILT_IDLE:   cnt_d = {CW{1'b0}};
            FILT_COUNT:  cnt_d = cnt_q + CW'(1);
            FILT_UPDATE: begin
                q_d   = s;
                cnt_d = {CW{1'b0}};
            end
            default:     cnt_d = {CW{1'b0}};
        endcase
    end

    // Channel state registers; reset wins over enable, disabled cycles hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= {DEPTH{1'b0}};
            cnt_q  <= {CW{1'b0}};
            q_q    <= 1'b0;
        end else if (clk__enable) begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            q_q    <= q_d;
        end
    end

`ifdef TECH_SYNC_FILTER_EDGES_EN
    logic rise_d, rise_q, fall_d, fall_q;

    // A pulse marks exactly the enabled cycle on which q takes a new value.
    always_comb begin
        if (act == FILT_UPDATE) begin
            rise_d = s;
            fall_d = ~s;
        end else begin
            rise_d = 1'b0;
            fall_d = 1'b0;
        end
    end

    // Edge pulse registers; held, not cleared, while the enable is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else if (clk__enable) begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise   = rise_q;
    assign fall   = fall_q;
    assign edge_o = rise_d | fall_d;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/tech_sync_filter.sv
// tech_sync_filter: WIDTH independent synchronised, glitch-filtered level
// inputs. Edge outputs (rise/fall/changed) exist only when the macro
// TECH_SYNC_FILTER_EDGES_EN is defined; otherwise they are tied to 0.
// Channels are not coherent with one another: never use this for buses.
module tech_sync_filter
    import tech_sync_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             clk__enable,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    if (WIDTH < 1) begin : g_bad_width
        $error("tech_sync_filter: WIDTH must be >= 1");
    end
    if (DEPTH < MIN_DEPTH) begin : g_bad_depth
        $error("tech_sync_filter: DEPTH must be >= 2");
    end
    if (FILTER_CYCLES < MIN_FILTER_CYCLES) begin : g_bad_fc
        $error("tech_sync_filter: FILTER_CYCLES must be >= 1");
    end

`ifdef TECH_SYNC_FILTER_EDGES_EN
    logic [WIDTH-1:0] edge_s;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        tech_sync_filter_chan #(
            .DEPTH         (DEPTH),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_chan (
            .clk         (clk),
            .clk__enable (clk__enable),
            .reset_n     (reset_n),
            .d           (d[i]),
            .q           (q[i]),
            .rise        (rise[i]),
            .fall        (fall[i])
`ifdef TECH_SYNC_FILTER_EDGES_EN
            ,
            .edge_o      (edge_s[i])
`endif
        );
    end

`ifdef TECH_SYNC_FILTER_EDGES_EN
    logic changed_d, changed_q;

    // Any channel producing a pulse this cycle raises changed alongside it.
    always_comb begin
        changed_d = |edge_s;
    end

    // changed register follows the same reset/enable rules as the pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            changed_q <= 1'b0;
        end else if (clk__enable) begin
            changed_q <= changed_d;
        end
    end

    assign changed = changed_q;
`else
    assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_tech_sync_filter.sv
// Self-checking bench for tech_sync_filter (default parameters). Works with
// TECH_SYNC_FILTER_EDGES_EN defined or undefined.
module tb_tech_sync_filter;

    localparam int W  = 8;
    localparam int DP = 2;
    localparam int FC = 4;
    localparam int HL = DP + FC;

`ifdef TECH_SYNC_FILTER_EDGES_EN
    localparam bit EDGES = 1'b1;
`else
    localparam bit EDGES = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clk__enable;
    logic         reset_n;
    logic [W-1:0] d;
    logic [W-1:0] q, rise, fall;
    logic         changed;

    int n_checks = 0;
    int n_fail   = 0;

    tech_sync_filter #(.WIDTH(W), .DEPTH(DP), .FILTER_CYCLES(FC)) dut (
        .clk         (clk),
        .clk__enable (clk__enable),
        .reset_n     (reset_n),
        .d           (d),
        .q           (q),
        .rise        (rise),
        .fall        (fall),
        .changed     (changed)
    );

    always #5 clk = ~clk;

    // Reference: history of d as sampled on enabled edges. q flips once the
    // last FC synchronised samples (each DP edges old) all disagree with it.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_q, m_rise, m_fall;
    logic         m_ch;

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < HL; k++) hist.push_back({W{1'b0}});
        m_q = '0; m_rise = '0; m_fall = '0; m_ch = 1'b0;
    endtask

    task automatic model_step(input logic rn, input logic en, input logic [W-1:0] dv);
        logic [W-1:0] nr, nf;
        logic         all_diff;
        if (!rn) begin
            model_reset();
        end else if (en) begin
            nr = '0; nf = '0;
            for (int i = 0; i < W; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < FC; j++)
                    if (hist[HL-DP-j][i] == m_q[i]) all_diff = 1'b0;
                nr[i] = all_diff & ~m_q[i];
                nf[i] = all_diff &  m_q[i];
            end
            m_q    = m_q ^ (nr | nf);
            m_rise = nr & {W{EDGES}};
            m_fall = nf & {W{EDGES}};
            m_ch   = EDGES & (|(nr | nf));
            hist.push_back(dv);
            void'(hist.pop_front());
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
    task automatic step(input logic rn, input logic en, input logic [W-1:0] dv);
        reset_n = rn; clk__enable = en; d = dv;
        @(posedge clk);
        model_step(rn, en, dv);
        #1;
        chk("model_q",       32'(q),       32'(m_q));
        chk("model_rise",    32'(rise),    32'(m_rise));
        chk("model_fall",    32'(fall),    32'(m_fall));
        chk("model_changed", 32'(changed), 32'(m_ch));
    endtask

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [W-1:0] f;
        logic         ch;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [W-1:0] dv, input logic [W-1:0] qv,
                       input logic [W-1:0] rv, input logic [W-1:0] fv, input logic cv);
        tbl.push_back('{d: dv, q: qv, r: rv, f: fv, ch: cv});
    endtask

    logic [W-1:0] rd;
    logic         e;
    int           ne;

    initial begin
        model_reset();
        // Latency on d[0], a 3-cycle glitch and a 4-cycle hold on d[3].
        for (int k = 0; k < 5; k++) add(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        add(8'h01, 8'h01, 8'h01, 8'h00, 1'b1);
        add(8'h01, 8'h01, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) add(8'h09, 8'h01, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 6; k++) add(8'h01, 8'h01, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) add(8'h09, 8'h01, 8'h00, 8'h00, 1'b0);
        add(8'h01, 8'h01, 8'h00, 8'h00, 1'b0);
        add(8'h01, 8'h09, 8'h08, 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) add(8'h01, 8'h09, 8'h00, 8'h00, 1'b0);
        add(8'h01, 8'h01, 8'h00, 8'h08, 1'b1);
        add(8'h01, 8'h01, 8'h00, 8'h00, 1'b0);

        // Reset with all inputs high: every output stays 0.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 8'hFF);
            chk("rst_q",       32'(q),       32'h0);
            chk("rst_rise",    32'(rise),    32'h0);
            chk("rst_fall",    32'(fall),    32'h0);
            chk("rst_changed", 32'(changed), 32'h0);
        end
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 8'h00);

        // Table of single-cycle vectors.
        foreach (tbl[i]) begin
            step(1'b1, 1'b1, tbl[i].d);
            chk("tbl_q",       32'(q),       32'(tbl[i].q));
            chk("tbl_rise",    32'(rise),    32'(tbl[i].r & {W{EDGES}}));
            chk("tbl_fall",    32'(fall),    32'(tbl[i].f & {W{EDGES}}));
            chk("tbl_changed", 32'(changed), 32'(tbl[i].ch & EDGES));
        end

        // Simultaneous transitions on several channels.
        step(1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 8'h00);
        for (int k = 1; k <= 7; k++) begin
            step(1'b1, 1'b1, 8'hA5);
            if (k == 5) chk("sim_q_early", 32'(q), 32'h00);
            if (k == 6) begin
                chk("sim_q",       32'(q),       32'hA5);
                chk("sim_rise",    32'(rise),    32'(8'hA5 & {W{EDGES}}));
                chk("sim_changed", 32'(changed), 32'(EDGES));
            end
            if (k == 7) chk("sim_rise_end", 32'(rise), 32'h00);
        end
        for (int k = 1; k <= 7; k++) begin
            step(1'b1, 1'b1, 8'h00);
            if (k == 6) begin
                chk("sim_fall_q", 32'(q),    32'h00);
                chk("sim_fall",   32'(fall), 32'(8'hA5 & {W{EDGES}}));
            end
            if (k == 7) chk("sim_fall_end", 32'(fall), 32'h00);
        end

        // Enable toggling 1010 while d[1] rises.
        step(1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 8'h00);
        ne = 0;
        for (int c = 0; c < 16; c++) begin
            e = (c % 2 == 0);
            step(1'b1, e, 8'h02);
            if (e) ne++;
            if (e && ne == 5) chk("en_q_early", 32'(q), 32'h00);
            if (e && ne == 6) begin
                chk("en_q",    32'(q),    32'h02);
                chk("en_rise", 32'(rise), 32'(8'h02 & {W{EDGES}}));
            end
            if (!e && ne == 6) begin
                chk("en_rise_held",    32'(rise),    32'(8'h02 & {W{EDGES}}));
                chk("en_changed_held", 32'(changed), 32'(EDGES));
            end
            if (e && ne == 7) chk("en_rise_end", 32'(rise), 32'h00);
        end

        // Reset in the middle of a count discards it.
        step(1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 8'h00);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 8'h04);
        step(1'b0, 1'b1, 8'h04);
        chk("mid_rst_q",    32'(q),    32'h00);
        chk("mid_rst_rise", 32'(rise), 32'h00);
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b1, 8'h04);
            if (k < 6) chk("mid_q_wait", 32'(q), 32'h00);
            if (k == 6) begin
                chk("mid_q",    32'(q),    32'h04);
                chk("mid_rise", 32'(rise), 32'(8'h04 & {W{EDGES}}));
            end
        end

        // Randomised traffic against the reference.
        step(1'b0, 1'b1, 8'h00);
        rd = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(5) == 0) rd[b] = ~rd[b];
            step(($urandom_range(199) != 0), ($urandom_range(3) != 0), rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
